multi_alarm_unit: RTL and testbench
===================================

MULTI_ALARM_UNIT -- requirements
Module: multi_alarm_unit

Interface
REQ-001 SHALL have parameter N_ALARMS, default 4: number of independent alarm channels (1..16).
REQ-002 SHALL have parameter SNOOZE_SEC, default 300: snooze delay in seconds (1..65535).
REQ-003 SHALL have parameter RING_TIMEOUT_SEC, default 60: auto-silence after this many seconds of ringing.
REQ-004 SHALL have parameter MAX_SNOOZE, default 3: snoozes allowed per ring episode.
REQ-005 SHALL have these ports, in order:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- sec_tick  input  1  one-cycle pulse per elapsed second.
- current_24_hour / current_24_min / current_24_sec  input  8 each  live 24-hour time.
- set_alarm  input  1  write pulse.
- alarm_sel  input  clog2(N_ALARMS), min 1  target channel.
- alarm_input_hour / alarm_input_min / alarm_input_sec  input  8 each  time to program.
- alarm_enable  input  1  written with set_alarm; 0 disarms the channel.
- snooze_alarm  input  1  level; rising edge acts.
- stop_alarm  input  1  level; rising edge acts.
- alarm_ringing  output  N_ALARMS  per-channel ringing flags.
- alarm_buzzer  output  1  OR of alarm_ringing.
- active_alarm  output  clog2(N_ALARMS), min 1  lowest ringing index; 0 when none.
- snooze_left  output  4  snoozes remaining for active_alarm.

Function
REQ-006 Each channel SHALL run its own FSM with states IDLE, ARMED, RINGING, SNOOZED.
REQ-007 set_alarm SHALL, on the same clock edge, latch time and enable into channel alarm_sel:
- enable=1 -> ARMED.
- enable=0 -> IDLE.
- Any state is overridden, including RINGING. Snooze count and timers clear.
REQ-008 set_alarm with an out-of-range alarm_sel SHALL be ignored.
REQ-009 Programmed values with hour>23, min>59 or sec>59 SHALL be rejected; the channel stays unchanged.
REQ-010 Trigger condition: ARMED, sec_tick high, and current time equal to programmed time. ARMED -> RINGING on the next edge; alarm_ringing bit high 1 cycle after that tick.
REQ-011 A channel SHALL trigger at most once per match second.
REQ-012 A channel SHALL re-arm after ringing ends and trigger again 24 h later.
REQ-013 snooze_alarm rising edge:
- Applies to every RINGING channel whose snooze count < MAX_SNOOZE.
- Each such channel -> SNOOZED, countdown loaded with SNOOZE_SEC, count incremented.
- Channels at the limit keep ringing.
REQ-014 SNOOZED countdown SHALL decrement on sec_tick. On reaching 0 -> RINGING and ring timer reloaded.
REQ-015 stop_alarm rising edge: every RINGING or SNOOZED channel -> ARMED, snooze count cleared.
REQ-016 stop_alarm SHALL take priority over snooze_alarm when both rise in the same cycle.
REQ-017 set_alarm SHALL take priority over stop/snooze for the addressed channel only.
REQ-018 Ring timeout: ring timer decrements on sec_tick while RINGING. On reaching 0 -> ARMED, snooze count cleared.
REQ-019 Simultaneous triggers on several channels SHALL all ring. active_alarm/snooze_left report the lowest index.
REQ-020 Outputs SHALL be registered or decoded only from registered state. No combinational path from snooze/stop to outputs.

Reset
REQ-021 reset low SHALL asynchronously force, for all channels:
- state IDLE, stored time 0, counters 0, edge-detect registers 0.
- Outputs: alarm_ringing=0, alarm_buzzer=0, active_alarm=0, snooze_left=0.
REQ-022 Reset deasserted mid-ring SHALL leave every channel IDLE. Alarms must be reprogrammed.

Structure
REQ-023 Package clock_pkg SHALL hold the alarm state enum, the time-field width (8), and the hour/min/sec limit constants.
REQ-024 Per-channel logic SHALL be the sub-module alarm_channel, instantiated N_ALARMS times by generate. The top holds edge detection, OR/priority encoding and the snooze_left mux.

Verification
REQ-025 Reset, program ch1=00:00:30, time 00:00:29 -> 00:00:30 tick -> alarm_ringing=4'b0010, buzzer=1, active_alarm=1 one cycle later.
REQ-026 Ringing ch1, snooze pulse -> ringing=0, snooze_left=2 when re-ringing. After 300 ticks -> ch1 rings again.
REQ-027 Snooze 3 times, then 4th snooze -> ch1 stays ringing. 60 ticks later -> auto-silenced, state ARMED.
REQ-028 ch0 and ch2 both at 12:00:00, tick -> ringing=4'b0101, active_alarm=0. stop_alarm -> both silent.
REQ-029 Program hour=24 -> rejected, channel unchanged. snooze and stop same cycle -> stop wins, nothing SNOOZED.
REQ-030 Assert reset while ch3 is SNOOZED -> all outputs 0 immediately. Countdown expiry after reset -> no ring.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the multi-channel alarm unit.
package clock_pkg;

  // Width of each hour/minute/second field
  localparam int TIME_W = 8;

  // Largest legal value of each time field
  localparam logic [TIME_W-1:0] HOUR_MAX = 8'd23;
  localparam logic [TIME_W-1:0] MIN_MAX  = 8'd59;
  localparam logic [TIME_W-1:0] SEC_MAX  = 8'd59;

  // Per-channel alarm state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZED = 2'd3
  } alarm_state_e;

  // True when a programmed time lies inside a 24-hour day
  function automatic logic time_valid(input logic [TIME_W-1:0] hour,
                                      input logic [TIME_W-1:0] min,
                                      input logic [TIME_W-1:0] sec);
    return (hour <= HOUR_MAX) && (min <= MIN_MAX) && (sec <= SEC_MAX);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored time, IDLE/ARMED/RINGING/SNOOZED FSM,
// snooze countdown, ring timeout and snooze counter.
// i_snooze / i_stop are single-cycle rising-edge pulses from the top;
// i_set is already qualified (channel selected, time valid).
module alarm_channel
  import clock_pkg::*;
#(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_sec_tick,
  input  logic [TIME_W-1:0] i_cur_hour,
  input  logic [TIME_W-1:0] i_cur_min,
  input  logic [TIME_W-1:0] i_cur_sec,
  input  logic              i_set,
  input  logic [TIME_W-1:0] i_set_hour,
  input  logic [TIME_W-1:0] i_set_min,
  input  logic [TIME_W-1:0] i_set_sec,
  input  logic              i_set_enable,
  input  logic              i_snooze,
  input  logic              i_stop,
  output alarm_state_e      o_state,
  output logic [3:0]        o_snooze_cnt
);

  localparam logic [15:0] SNOOZE_LD = 16'(SNOOZE_SEC);
  localparam logic [15:0] RING_LD   = 16'(RING_TIMEOUT_SEC);
  localparam logic [3:0]  MAX_CNT   = 4'(MAX_SNOOZE);

  alarm_state_e      r_state,      w_state_nxt;
  logic [TIME_W-1:0] r_hour,       w_hour_nxt;
  logic [TIME_W-1:0] r_min,        w_min_nxt;
  logic [TIME_W-1:0] r_sec,        w_sec_nxt;
  logic [3:0]        r_snooze_cnt, w_snooze_cnt_nxt;
  logic [15:0]       r_snooze_tmr, w_snooze_tmr_nxt;
  logic [15:0]       r_ring_tmr,   w_ring_tmr_nxt;
  // Set once this channel has fired for the current matching second;
  // cleared as soon as the live time no longer matches.
  logic              r_fired,      w_fired_nxt;
  logic              w_match;

  assign w_match = (i_cur_hour == r_hour) && (i_cur_min == r_min) &&
                   (i_cur_sec == r_sec);

  // State register: every field of the channel, async active-low clear
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_hour       <= '0;
      r_min        <= '0;
      r_sec        <= '0;
      r_snooze_cnt <= '0;
      r_snooze_tmr <= '0;
      r_ring_tmr   <= '0;
      r_fired      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hour       <= w_hour_nxt;
      r_min        <= w_min_nxt;
      r_sec        <= w_sec_nxt;
      r_snooze_cnt <= w_snooze_cnt_nxt;
      r_snooze_tmr <= w_snooze_tmr_nxt;
      r_ring_tmr   <= w_ring_tmr_nxt;
      r_fired      <= w_fired_nxt;
    end
  end

  // Next-state logic: programming beats stop, stop beats snooze, snooze beats tick
  always_comb begin
    w_state_nxt      = r_state;
    w_hour_nxt       = r_hour;
    w_min_nxt        = r_min;
    w_sec_nxt        = r_sec;
    w_snooze_cnt_nxt = r_snooze_cnt;
    w_snooze_tmr_nxt = r_snooze_tmr;
    w_ring_tmr_nxt   = r_ring_tmr;
    w_fired_nxt      = r_fired;

    if (i_set) begin
      w_hour_nxt       = i_set_hour;
      w_min_nxt        = i_set_min;
      w_sec_nxt        = i_set_sec;
      w_state_nxt      = i_set_enable ? ST_ARMED : ST_IDLE;
      w_snooze_cnt_nxt = '0;
      w_snooze_tmr_nxt = '0;
      w_ring_tmr_nxt   = '0;
      w_fired_nxt      = 1'b0;
    end else begin
      if (!w_match) begin
        w_fired_nxt = 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_ARMED: begin
          if (i_sec_tick && w_match && !r_fired) begin
            w_state_nxt    = ST_RINGING;
            w_ring_tmr_nxt = RING_LD;
            w_fired_nxt    = 1'b1;
          end
        end
        ST_RINGING: begin
          if (i_stop) begin
            w_state_nxt      = ST_ARMED;
            w_snooze_cnt_nxt = '0;
            w_ring_tmr_nxt   = '0;
          end else if (i_snooze && (r_snooze_cnt < MAX_CNT)) begin
            w_state_nxt      = ST_SNOOZED;
            w_snooze_tmr_nxt = SNOOZE_LD;
            w_snooze_cnt_nxt = r_snooze_cnt + 4'd1;
          end else if (i_sec_tick) begin
            if (r_ring_tmr <= 16'd1) begin
              w_state_nxt      = ST_ARMED;
              w_snooze_cnt_nxt = '0;
              w_ring_tmr_nxt   = '0;
            end else begin
              w_ring_tmr_nxt = r_ring_tmr - 16'd1;
            end
          end
        end
        ST_SNOOZED: begin
          if (i_stop) begin
            w_state_nxt      = ST_ARMED;
            w_snooze_cnt_nxt = '0;
            w_snooze_tmr_nxt = '0;
          end else if (i_sec_tick) begin
            if (r_snooze_tmr <= 16'd1) begin
              w_state_nxt      = ST_RINGING;
              w_snooze_tmr_nxt = '0;
              w_ring_tmr_nxt   = RING_LD;
            end else begin
              w_snooze_tmr_nxt = r_snooze_tmr - 16'd1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_snooze_cnt = r_snooze_cnt;

endmodule

// File: rtl/multi_alarm_unit.sv
// Multi-channel alarm unit: snooze/stop edge detection, write qualification,
// N_ALARMS alarm_channel instances, ringing OR and lowest-index priority encode.
// Outputs are decoded only from channel state registers.
module multi_alarm_unit
  import clock_pkg::*;
#(
  parameter int N_ALARMS         = 4,
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3,
  localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sec_tick,
  input  logic [TIME_W-1:0]   current_24_hour,
  input  logic [TIME_W-1:0]   current_24_min,
  input  logic [TIME_W-1:0]   current_24_sec,
  input  logic                set_alarm,
  input  logic [AW-1:0]       alarm_sel,
  input  logic [TIME_W-1:0]   alarm_input_hour,
  input  logic [TIME_W-1:0]   alarm_input_min,
  input  logic [TIME_W-1:0]   alarm_input_sec,
  input  logic                alarm_enable,
  input  logic                snooze_alarm,
  input  logic                stop_alarm,
  output logic [N_ALARMS-1:0] alarm_ringing,
  output logic                alarm_buzzer,
  output logic [AW-1:0]       active_alarm,
  output logic [3:0]          snooze_left
);

  localparam logic [AW:0] N_LIM   = (AW + 1)'(N_ALARMS);
  localparam logic [3:0]  MAX_CNT = 4'(MAX_SNOOZE);

  logic                r_snooze_d;
  logic                r_stop_d;
  logic                w_snooze_rise;
  logic                w_stop_rise;
  logic                w_set_ok;
  alarm_state_e        w_state [N_ALARMS];
  logic [3:0]          w_cnt   [N_ALARMS];
  logic [N_ALARMS-1:0] w_ringing;
  logic [AW-1:0]       w_active;
  logic [3:0]          w_left;

  // Edge-detect history for the snooze and stop levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snooze_d <= 1'b0;
      r_stop_d   <= 1'b0;
    end else begin
      r_snooze_d <= snooze_alarm;
      r_stop_d   <= stop_alarm;
    end
  end

  assign w_snooze_rise = snooze_alarm & ~r_snooze_d;
  assign w_stop_rise   = stop_alarm & ~r_stop_d;

  // A write lands only on an existing channel with a legal time
  assign w_set_ok = set_alarm && ({1'b0, alarm_sel} < N_LIM) &&
                    time_valid(alarm_input_hour, alarm_input_min, alarm_input_sec);

  for (genvar g = 0; g < N_ALARMS; g++) begin : g_ch
    alarm_channel #(
      .SNOOZE_SEC       (SNOOZE_SEC),
      .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC),
      .MAX_SNOOZE       (MAX_SNOOZE)
    ) u_ch (
      .clk          (clk),
      .i_rst_n      (reset),
      .i_sec_tick   (sec_tick),
      .i_cur_hour   (current_24_hour),
      .i_cur_min    (current_24_min),
      .i_cur_sec    (current_24_sec),
      .i_set        (w_set_ok && (alarm_sel == AW'(g))),
      .i_set_hour   (alarm_input_hour),
      .i_set_min    (alarm_input_min),
      .i_set_sec    (alarm_input_sec),
      .i_set_enable (alarm_enable),
      .i_snooze     (w_snooze_rise),
      .i_stop       (w_stop_rise),
      .o_state      (w_state[g]),
      .o_snooze_cnt (w_cnt[g])
    );
    assign w_ringing[g] = (w_state[g] == ST_RINGING);
  end

  // Lowest ringing index wins; scan from the top so the lowest is written last
  always_comb begin
    w_active = '0;
    w_left   = '0;
    for (int k = N_ALARMS - 1; k >= 0; k--) begin
      if (w_ringing[k]) begin
        w_active = AW'(k);
        w_left   = MAX_CNT - w_cnt[k];
      end
    end
  end

  assign alarm_ringing = w_ringing;
  assign alarm_buzzer  = |w_ringing;
  assign active_alarm  = w_active;
  assign snooze_left   = w_left;

endmodule

// File: tb/tb_multi_alarm_unit.sv
// Directed bench for multi_alarm_unit with default parameters
// (4 channels, 300 s snooze, 60 s ring timeout, 3 snoozes).
module tb_multi_alarm_unit;
  import clock_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sec_tick = 1'b0;
  logic [7:0] current_24_hour = '0;
  logic [7:0] current_24_min = '0;
  logic [7:0] current_24_sec = '0;
  logic       set_alarm = 1'b0;
  logic [1:0] alarm_sel = '0;
  logic [7:0] alarm_input_hour = '0;
  logic [7:0] alarm_input_min = '0;
  logic [7:0] alarm_input_sec = '0;
  logic       alarm_enable = 1'b0;
  logic       snooze_alarm = 1'b0;
  logic       stop_alarm = 1'b0;
  logic [3:0] alarm_ringing;
  logic       alarm_buzzer;
  logic [1:0] active_alarm;
  logic [3:0] snooze_left;

  int n_cmp = 0;
  int n_err = 0;

  multi_alarm_unit dut (
    .clk              (clk),
    .reset            (reset),
    .sec_tick         (sec_tick),
    .current_24_hour  (current_24_hour),
    .current_24_min   (current_24_min),
    .current_24_sec   (current_24_sec),
    .set_alarm        (set_alarm),
    .alarm_sel        (alarm_sel),
    .alarm_input_hour (alarm_input_hour),
    .alarm_input_min  (alarm_input_min),
    .alarm_input_sec  (alarm_input_sec),
    .alarm_enable     (alarm_enable),
    .snooze_alarm     (snooze_alarm),
    .stop_alarm       (stop_alarm),
    .alarm_ringing    (alarm_ringing),
    .alarm_buzzer     (alarm_buzzer),
    .active_alarm     (active_alarm),
    .snooze_left      (snooze_left)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    current_24_hour = h;
    current_24_min  = m;
    current_24_sec  = s;
  endtask

  task automatic do_tick();
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
  endtask

  task automatic program_ch(input logic [1:0] sel, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s, input logic en);
    alarm_sel        = sel;
    alarm_input_hour = h;
    alarm_input_min  = m;
    alarm_input_sec  = s;
    alarm_enable     = en;
    set_alarm        = 1'b1;
    step(1);
    set_alarm        = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze_alarm = 1'b1;
    step(1);
    snooze_alarm = 1'b0;
    step(1);
  endtask

  task automatic pulse_stop();
    stop_alarm = 1'b1;
    step(1);
    stop_alarm = 1'b0;
    step(1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    step(2);
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL reset_ringing: got %b exp %b", alarm_ringing, 4'b0000); end
    n_cmp++; if (alarm_buzzer !== 1'b0) begin n_err++; $display("FAIL reset_buzzer: got %b exp 0", alarm_buzzer); end
    n_cmp++; if (active_alarm !== 2'd0) begin n_err++; $display("FAIL reset_active: got %0d exp 0", active_alarm); end
    n_cmp++; if (snooze_left !== 4'd0) begin n_err++; $display("FAIL reset_snooze_left: got %0d exp 0", snooze_left); end
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_basic_trigger();
    program_ch(2'd1, 8'd0, 8'd0, 8'd30, 1'b1);
    set_time(8'd0, 8'd0, 8'd29);
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL early_tick: got %b exp %b", alarm_ringing, 4'b0000); end
    set_time(8'd0, 8'd0, 8'd30);
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0010) begin n_err++; $display("FAIL trig_ringing: got %b exp %b", alarm_ringing, 4'b0010); end
    n_cmp++; if (alarm_buzzer !== 1'b1) begin n_err++; $display("FAIL trig_buzzer: got %b exp 1", alarm_buzzer); end
    n_cmp++; if (active_alarm !== 2'd1) begin n_err++; $display("FAIL trig_active: got %0d exp 1", active_alarm); end
    n_cmp++; if (snooze_left !== 4'd3) begin n_err++; $display("FAIL trig_snooze_left: got %0d exp 3", snooze_left); end
    pulse_stop();
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL stop_ringing: got %b exp %b", alarm_ringing, 4'b0000); end
    // Second tick stamped with the same second must not fire again
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL once_per_second: got %b exp %b", alarm_ringing, 4'b0000); end
  endtask

  task automatic test_snooze();
    program_ch(2'd1, 8'd0, 8'd0, 8'd40, 1'b1);
    set_time(8'd0, 8'd0, 8'd40);
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0010) begin n_err++; $display("FAIL snz_trig: got %b exp %b", alarm_ringing, 4'b0010); end
    pulse_snooze();
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL snz_silent: got %b exp %b", alarm_ringing, 4'b0000); end
    n_cmp++; if (dut.w_state[1] !== ST_SNOOZED) begin n_err++; $display("FAIL snz_state: got %0d exp %0d", dut.w_state[1], ST_SNOOZED); end
    set_time(8'd0, 8'd1, 8'd0);
    for (int i = 0; i < 299; i++) do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL snz_299: got %b exp %b", alarm_ringing, 4'b0000); end
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0010) begin n_err++; $display("FAIL snz_300: got %b exp %b", alarm_ringing, 4'b0010); end
    n_cmp++; if (snooze_left !== 4'd2) begin n_err++; $display("FAIL snz_left2: got %0d exp 2", snooze_left); end
  endtask

  task automatic test_snooze_limit();
    for (int k = 0; k < 2; k++) begin
      pulse_snooze();
      for (int i = 0; i < 300; i++) do_tick();
    end
    n_cmp++; if (alarm_ringing !== 4'b0010) begin n_err++; $display("FAIL lim_rering: got %b exp %b", alarm_ringing, 4'b0010); end
    n_cmp++; if (snooze_left !== 4'd0) begin n_err++; $display("FAIL lim_left0: got %0d exp 0", snooze_left); end
    pulse_snooze();
    n_cmp++; if (alarm_ringing !== 4'b0010) begin n_err++; $display("FAIL lim_4th_snooze: got %b exp %b", alarm_ringing, 4'b0010); end
    for (int i = 0; i < 59; i++) do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0010) begin n_err++; $display("FAIL timeout_59: got %b exp %b", alarm_ringing, 4'b0010); end
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL timeout_60: got %b exp %b", alarm_ringing, 4'b0000); end
    n_cmp++; if (dut.w_state[1] !== ST_ARMED) begin n_err++; $display("FAIL timeout_state: got %0d exp %0d", dut.w_state[1], ST_ARMED); end
  endtask

  task automatic test_simultaneous();
    program_ch(2'd0, 8'd12, 8'd0, 8'd0, 1'b1);
    program_ch(2'd2, 8'd12, 8'd0, 8'd0, 1'b1);
    set_time(8'd12, 8'd0, 8'd0);
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0101) begin n_err++; $display("FAIL sim_ringing: got %b exp %b", alarm_ringing, 4'b0101); end
    n_cmp++; if (active_alarm !== 2'd0) begin n_err++; $display("FAIL sim_active: got %0d exp 0", active_alarm); end
    n_cmp++; if (alarm_buzzer !== 1'b1) begin n_err++; $display("FAIL sim_buzzer: got %b exp 1", alarm_buzzer); end
    pulse_stop();
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL sim_stop: got %b exp %b", alarm_ringing, 4'b0000); end
    n_cmp++; if (alarm_buzzer !== 1'b0) begin n_err++; $display("FAIL sim_stop_buzzer: got %b exp 0", alarm_buzzer); end
  endtask

  task automatic test_reject_and_stop_priority();
    program_ch(2'd3, 8'd12, 8'd30, 8'd0, 1'b1);
    // Each illegal write tries to disarm ch3; none may land
    program_ch(2'd3, 8'd24, 8'd30, 8'd0, 1'b0);
    n_cmp++; if (dut.w_state[3] !== ST_ARMED) begin n_err++; $display("FAIL rej_hour24: got %0d exp %0d", dut.w_state[3], ST_ARMED); end
    program_ch(2'd3, 8'd12, 8'd60, 8'd0, 1'b0);
    n_cmp++; if (dut.w_state[3] !== ST_ARMED) begin n_err++; $display("FAIL rej_min60: got %0d exp %0d", dut.w_state[3], ST_ARMED); end
    program_ch(2'd3, 8'd12, 8'd30, 8'd60, 1'b0);
    n_cmp++; if (dut.w_state[3] !== ST_ARMED) begin n_err++; $display("FAIL rej_sec60: got %0d exp %0d", dut.w_state[3], ST_ARMED); end
    set_time(8'd12, 8'd30, 8'd0);
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b1000) begin n_err++; $display("FAIL rej_time_kept: got %b exp %b", alarm_ringing, 4'b1000); end
    n_cmp++; if (active_alarm !== 2'd3) begin n_err++; $display("FAIL rej_active: got %0d exp 3", active_alarm); end
    snooze_alarm = 1'b1;
    stop_alarm   = 1'b1;
    step(1);
    snooze_alarm = 1'b0;
    stop_alarm   = 1'b0;
    step(1);
    n_cmp++; if (dut.w_state[3] !== ST_ARMED) begin n_err++; $display("FAIL stop_over_snooze: got %0d exp %0d", dut.w_state[3], ST_ARMED); end
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL stop_over_snooze_ring: got %b exp %b", alarm_ringing, 4'b0000); end
  endtask

  task automatic test_set_priority();
    program_ch(2'd0, 8'd13, 8'd0, 8'd0, 1'b1);
    program_ch(2'd2, 8'd13, 8'd0, 8'd0, 1'b1);
    set_time(8'd13, 8'd0, 8'd0);
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0101) begin n_err++; $display("FAIL setp_trig: got %b exp %b", alarm_ringing, 4'b0101); end
    // Reprogram ch0 in the same cycle as a snooze edge
    alarm_sel        = 2'd0;
    alarm_input_hour = 8'd13;
    alarm_input_min  = 8'd5;
    alarm_input_sec  = 8'd0;
    alarm_enable     = 1'b1;
    set_alarm        = 1'b1;
    snooze_alarm     = 1'b1;
    step(1);
    set_alarm    = 1'b0;
    snooze_alarm = 1'b0;
    step(1);
    n_cmp++; if (dut.w_state[0] !== ST_ARMED) begin n_err++; $display("FAIL setp_ch0: got %0d exp %0d", dut.w_state[0], ST_ARMED); end
    n_cmp++; if (dut.w_state[2] !== ST_SNOOZED) begin n_err++; $display("FAIL setp_ch2: got %0d exp %0d", dut.w_state[2], ST_SNOOZED); end
    pulse_stop();
    n_cmp++; if (dut.w_state[2] !== ST_ARMED) begin n_err++; $display("FAIL setp_stop_snoozed: got %0d exp %0d", dut.w_state[2], ST_ARMED); end
  endtask

  task automatic test_rearm();
    set_time(8'd13, 8'd5, 8'd0);
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0001) begin n_err++; $display("FAIL rearm_first: got %b exp %b", alarm_ringing, 4'b0001); end
    pulse_stop();
    set_time(8'd13, 8'd5, 8'd1);
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL rearm_gap: got %b exp %b", alarm_ringing, 4'b0000); end
    // Time wraps back to the programmed second a day later
    set_time(8'd13, 8'd5, 8'd0);
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0001) begin n_err++; $display("FAIL rearm_next_day: got %b exp %b", alarm_ringing, 4'b0001); end
    pulse_stop();
  endtask

  task automatic test_reset_mid_snooze();
    program_ch(2'd3, 8'd14, 8'd0, 8'd0, 1'b1);
    set_time(8'd14, 8'd0, 8'd0);
    do_tick();
    n_cmp++; if (alarm_ringing !== 4'b1000) begin n_err++; $display("FAIL rst_trig: got %b exp %b", alarm_ringing, 4'b1000); end
    n_cmp++; if (active_alarm !== 2'd3) begin n_err++; $display("FAIL rst_trig_active: got %0d exp 3", active_alarm); end
    pulse_snooze();
    n_cmp++; if (dut.w_state[3] !== ST_SNOOZED) begin n_err++; $display("FAIL rst_pre_state: got %0d exp %0d", dut.w_state[3], ST_SNOOZED); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (dut.w_state[3] !== ST_IDLE) begin n_err++; $display("FAIL rst_async_state: got %0d exp %0d", dut.w_state[3], ST_IDLE); end
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL rst_async_ring: got %b exp %b", alarm_ringing, 4'b0000); end
    n_cmp++; if (snooze_left !== 4'd0) begin n_err++; $display("FAIL rst_async_left: got %0d exp 0", snooze_left); end
    #2 reset = 1'b1;
    step(1);
    set_time(8'd14, 8'd1, 8'd0);
    for (int i = 0; i < 300; i++) do_tick();
    n_cmp++; if (alarm_ringing !== 4'b0000) begin n_err++; $display("FAIL rst_no_ring: got %b exp %b", alarm_ringing, 4'b0000); end
    n_cmp++; if (dut.w_state[0] !== ST_IDLE) begin n_err++; $display("FAIL rst_ch0_idle: got %0d exp %0d", dut.w_state[0], ST_IDLE); end
    n_cmp++; if (alarm_buzzer !== 1'b0) begin n_err++; $display("FAIL rst_buzzer: got %b exp 0", alarm_buzzer); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_trigger();
    test_snooze();
    test_snooze_limit();
    test_simultaneous();
    test_reject_and_stop_priority();
    test_set_priority();
    test_rearm();
    test_reset_mid_snooze();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
